input_read_arbiter: RTL and testbench
=====================================

Name: input_read_arbiter

Overview:
- Shares the single pop port of the button-event FIFO inside input_controller between two consumers: the CPU load path and the graphics/game-logic engine.
- Performs round-robin arbitration and drives the FIFO read strobe.
- Waits out the FIFO read latency, captures the popped code, and returns it to the granted requester with a one-cycle valid pulse.
- Answers reads of an empty FIFO immediately with an empty flag and never pops.

Parameters:
- DATA_W, 4: width of a button event code (one bit per button).
- RD_LATENCY, 1: cycles from fifo_rd_en high until fifo_rd_data is valid. Legal range 1..7.

Ports:
- sys_clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted at 0.
- req_cpu  in  1  CPU read request (level). Held until rsp_valid_cpu.
- req_gfx  in  1  graphics engine read request (level). Held until rsp_valid_gfx.
- fifo_empty  in  1  FIFO empty status from input_controller.
- fifo_rd_data  in  DATA_W  FIFO output data (data_to_cpu).
- fifo_rd_en  out  1  FIFO pop strobe (cpu_read_en).
- rsp_valid_cpu  out  1  one-cycle response pulse to CPU.
- rsp_valid_gfx  out  1  one-cycle response pulse to graphics engine.
- rsp_data  out  DATA_W  response data, shared by both requesters.
- rsp_empty  out  1  response flag: FIFO was empty, rsp_data is 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0; lat_cnt=0.
  - last_grant=GFX, so the CPU wins the first tie.
  - A pop already issued when reset hits is lost; this is accepted.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that is not last_grant.
  - Grant while fifo_empty=1: go to RESP with rsp_data=0 and rsp_empty=1. No pop.
  - Grant while fifo_empty=0: go to ISSUE.
- ISSUE:
  - fifo_rd_en=1 for exactly this one cycle.
  - Load lat_cnt=RD_LATENCY-1, then go to WAIT.
- WAIT:
  - fifo_rd_en=0.
  - If lat_cnt=0: capture fifo_rd_data into rsp_data at this cycle's closing edge, set rsp_empty=0, go to RESP.
  - Otherwise decrement lat_cnt and stay in WAIT.
- RESP:
  - Pulse rsp_valid for the granted requester for one cycle.
  - rsp_data and rsp_empty stay stable during the pulse and hold until the next capture.
  - last_grant is updated to the granted requester; go to IDLE.
- Latency, request sampled in IDLE at cycle T:
  - Data path: fifo_rd_en during T+1; rsp_valid during T+2+RD_LATENCY (T+3 at default).
  - Empty path: rsp_valid during T+1.
- Throughput: IDLE lasts at least one cycle between transactions, so a new grant comes no earlier than the cycle after RESP. With both requesters held high, grants alternate strictly.
- Requester drops its request mid-transaction: the transaction still completes. The popped data is returned with the valid pulse and then discarded by the requester. The arbiter never pushes data back.
- fifo_empty is sampled only in IDLE. A change during ISSUE or WAIT has no effect.
- Never more than one fifo_rd_en per transaction. Never two rsp_valid outputs high in the same cycle.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Reset: hold reset=0 with req_cpu=1 and fifo_empty=0 for 5 cycles. Required: every output is 0, and fifo_rd_en is never high. Release reset, then the CPU is granted first.
- Single read: FIFO holds 4'b1000, req_cpu held from cycle T. Required: fifo_rd_en high only in T+1; rsp_valid_cpu pulses in T+3 with rsp_data=4'b1000 and rsp_empty=0; req_cpu drops afterwards and the arbiter returns to IDLE.
- Contention: FIFO holds 4'b1000, 4'b0010, 4'b0100, 4'b0001; req_cpu=req_gfx=1 held throughout. Required, in order:
  - CPU gets 1000.
  - GFX gets 0010.
  - CPU gets 0100.
  - GFX gets 0001.
  - Exactly 4 fifo_rd_en pulses in total.
- Empty read: fifo_empty=1, req_gfx at cycle T. Required: rsp_valid_gfx in T+1 with rsp_empty=1 and rsp_data=0; no fifo_rd_en.
- Latency parameter: set RD_LATENCY=3 with the FIFO returning 4'b0110. Required: rsp_valid in T+5 carrying 4'b0110; data captured only at the end of the third WAIT cycle.
- Abort and reset mid-operation:
  - Drop req_cpu during WAIT: rsp_valid_cpu still pulses.
  - Assert reset during WAIT: fifo_rd_en and busy go to 0 immediately; the next request after release starts a fresh transaction.

Source files
------------

// File: rtl/input_read_arbiter.sv
// input_read_arbiter: round-robin sharing of the button-event FIFO pop port
// between the CPU load path and the graphics engine. Every output is a flop.
module input_read_arbiter #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              req_cpu,
    input  logic              req_gfx,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              rsp_valid_cpu,
    output logic              rsp_valid_gfx,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_empty,
    output logic              busy
);

    localparam int unsigned          LAT_W    = 3;
    localparam logic [LAT_W-1:0]     LAT_LOAD = LAT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               grant_gfx_q, grant_gfx_d;   // 1 = graphics engine owns the transaction
    logic               last_gfx_q, last_gfx_d;     // 1 = graphics engine was served last
    logic               any_req_c;
    logic               pick_gfx_c;

    logic               fifo_rd_en_d;
    logic               rsp_valid_cpu_d;
    logic               rsp_valid_gfx_d;
    logic [DATA_W-1:0]  rsp_data_d;
    logic               rsp_empty_d;
    logic               busy_d;

    // State register plus the arbitration and latency bookkeeping
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            grant_gfx_q <= 1'b0;
            last_gfx_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            grant_gfx_q <= grant_gfx_d;
            last_gfx_q  <= last_gfx_d;
        end
    end

    // Next-state logic: round-robin pick in IDLE, then pop, wait, respond
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        grant_gfx_d = grant_gfx_q;
        last_gfx_d  = last_gfx_q;
        any_req_c   = req_cpu | req_gfx;
        pick_gfx_c  = req_gfx & (~req_cpu | ~last_gfx_q);

        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    grant_gfx_d = pick_gfx_c;
                    state_d     = fifo_empty ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                last_gfx_d = grant_gfx_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: next values of the output flops, derived from the upcoming state
    always_comb begin
        fifo_rd_en_d    = 1'b0;
        rsp_valid_cpu_d = 1'b0;
        rsp_valid_gfx_d = 1'b0;
        rsp_data_d      = rsp_data;
        rsp_empty_d     = rsp_empty;
        busy_d          = (state_d != IDLE);

        if (state_d == ISSUE) begin
            fifo_rd_en_d = 1'b1;
        end

        if (state_d == RESP) begin
            rsp_valid_cpu_d = ~grant_gfx_d;
            rsp_valid_gfx_d = grant_gfx_d;
        end

        // Empty FIFO answered straight from IDLE; real data captured on the last WAIT cycle
        if (state_q == IDLE && state_d == RESP) begin
            rsp_data_d  = '0;
            rsp_empty_d = 1'b1;
        end else if (state_q == WAIT && state_d == RESP) begin
            rsp_data_d  = fifo_rd_data;
            rsp_empty_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            fifo_rd_en    <= 1'b0;
            rsp_valid_cpu <= 1'b0;
            rsp_valid_gfx <= 1'b0;
            rsp_data      <= '0;
            rsp_empty     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            fifo_rd_en    <= fifo_rd_en_d;
            rsp_valid_cpu <= rsp_valid_cpu_d;
            rsp_valid_gfx <= rsp_valid_gfx_d;
            rsp_data      <= rsp_data_d;
            rsp_empty     <= rsp_empty_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_input_read_arbiter.sv
// tb_input_read_arbiter: two arbiters (read latency 1 and 3) against a FIFO model,
// transaction-level reference predictions and a scoreboard monitor.
module tb_input_read_arbiter;

    localparam int unsigned DW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT-side signals, index 0: RD_LATENCY=1, index 1: RD_LATENCY=3
    logic          rst_n [2] = '{1'b0, 1'b0};
    logic          req_cpu [2];
    logic          req_gfx [2];
    logic          fifo_empty [2];
    logic [DW-1:0] rd_data [2];
    logic          fifo_rd_en [2];
    logic          rsp_valid_cpu [2];
    logic          rsp_valid_gfx [2];
    logic [DW-1:0] rsp_data [2];
    logic          rsp_empty [2];
    logic          busy [2];

    // Requester bookkeeping: a requester holds its line until it has received tgt responses
    int   seen_cpu [2] = '{0, 0};
    int   seen_gfx [2] = '{0, 0};
    int   tgt_cpu  [2] = '{0, 0};
    int   tgt_gfx  [2] = '{0, 0};
    int   pops     [2] = '{0, 0};
    logic drop_cpu [2] = '{1'b0, 1'b0};

    // FIFO model storage
    logic [DW-1:0] fq[$];
    int            wr_cnt = 0;
    int            rd_ptr = 0;
    logic [DW-1:0] p0;
    logic [DW-1:0] p1 [3];

    // Scoreboard
    typedef struct {
        int            dut;
        bit            gfx;
        logic [DW-1:0] data;
        bit            empty;
        int            cyc;
    } exp_t;
    exp_t expq[$];

    int n_cmp = 0;
    int n_err = 0;
    bit last_gfx_m [2] = '{1'b1, 1'b1};
    int exp_pops [2] = '{0, 0};
    int pop_base [2] = '{0, 0};

    input_read_arbiter #(.DATA_W(DW), .RD_LATENCY(1)) dut0 (
        .sys_clock     (clk),
        .reset         (rst_n[0]),
        .req_cpu       (req_cpu[0]),
        .req_gfx       (req_gfx[0]),
        .fifo_empty    (fifo_empty[0]),
        .fifo_rd_data  (rd_data[0]),
        .fifo_rd_en    (fifo_rd_en[0]),
        .rsp_valid_cpu (rsp_valid_cpu[0]),
        .rsp_valid_gfx (rsp_valid_gfx[0]),
        .rsp_data      (rsp_data[0]),
        .rsp_empty     (rsp_empty[0]),
        .busy          (busy[0])
    );

    input_read_arbiter #(.DATA_W(DW), .RD_LATENCY(3)) dut1 (
        .sys_clock     (clk),
        .reset         (rst_n[1]),
        .req_cpu       (req_cpu[1]),
        .req_gfx       (req_gfx[1]),
        .fifo_empty    (fifo_empty[1]),
        .fifo_rd_data  (rd_data[1]),
        .fifo_rd_en    (fifo_rd_en[1]),
        .rsp_valid_cpu (rsp_valid_cpu[1]),
        .rsp_valid_gfx (rsp_valid_gfx[1]),
        .rsp_data      (rsp_data[1]),
        .rsp_empty     (rsp_empty[1]),
        .busy          (busy[1])
    );

    // Request levels and FIFO status derived from the bookkeeping counters
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req_cpu[i]    = (seen_cpu[i] < tgt_cpu[i]) && !drop_cpu[i];
            req_gfx[i]    = (seen_gfx[i] < tgt_gfx[i]);
            fifo_empty[i] = (rd_ptr >= wr_cnt);
        end
        rd_data[0] = p0;
        rd_data[1] = p1[2];
    end

    // FIFO read pipeline: popped word appears RD_LATENCY cycles later, garbage otherwise
    always @(posedge clk) begin
        logic [DW-1:0] head;
        head = (rd_ptr < fq.size()) ? fq[rd_ptr] : DW'($urandom);
        p0    <= fifo_rd_en[0] ? head : DW'($urandom);
        p1[0] <= fifo_rd_en[1] ? head : DW'($urandom);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        if (fifo_rd_en[0] || fifo_rd_en[1]) rd_ptr <= rd_ptr + 1;
    end

    function automatic void check(input bit ok, input string nm, input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic bit has_exp(input int i);
        foreach (expq[k]) if (expq[k].dut == i) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: pops expectations when a DUT presents a response
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                check({fifo_rd_en[i], rsp_valid_cpu[i], rsp_valid_gfx[i], rsp_data[i],
                       rsp_empty[i], busy[i]} == 9'd0, "reset_outputs",
                      int'({fifo_rd_en[i], rsp_valid_cpu[i], rsp_valid_gfx[i], rsp_data[i],
                            rsp_empty[i], busy[i]}), 0);
                for (int k = expq.size() - 1; k >= 0; k--)
                    if (expq[k].dut == i) expq.delete(k);
            end else begin
                if (fifo_rd_en[i]) pops[i]++;
                if (rsp_valid_cpu[i] && rsp_valid_gfx[i]) begin
                    check(1'b0, "dual_valid", 3, 1);
                end else if (rsp_valid_cpu[i] || rsp_valid_gfx[i]) begin
                    int   idx;
                    exp_t e;
                    idx = -1;
                    foreach (expq[k]) if (idx < 0 && expq[k].dut == i) idx = k;
                    if (idx < 0) begin
                        check(1'b0, "unexpected_valid", i, -1);
                    end else begin
                        e = expq[idx];
                        expq.delete(idx);
                        check(rsp_valid_gfx[i] == e.gfx, "grant_gfx", int'(rsp_valid_gfx[i]), int'(e.gfx));
                        check(rsp_data[i] == e.data, "rsp_data", int'(rsp_data[i]), int'(e.data));
                        check(rsp_empty[i] == e.empty, "rsp_empty", int'(rsp_empty[i]), int'(e.empty));
                        check(cyc == e.cyc, "rsp_cycle", cyc, e.cyc);
                    end
                    if (rsp_valid_gfx[i]) seen_gfx[i]++;
                    else                  seen_cpu[i]++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        fq.push_back(d);
        wr_cnt = wr_cnt + 1;
    endtask

    // Reference: serve nc CPU and ng GFX reads starting with IDLE sampling at cycle t0
    task automatic predict(input int i, input int nc, input int ng, input int t0);
        int   k, t, lat, np;
        bit   g;
        exp_t e;
        k   = rd_ptr;
        t   = t0;
        lat = (i == 0) ? 1 : 3;
        np  = 0;
        while (nc > 0 || ng > 0) begin
            g     = (nc > 0 && ng > 0) ? !last_gfx_m[i] : (ng > 0);
            e.dut = i;
            e.gfx = g;
            if (k < fq.size()) begin
                e.data  = fq[k];
                e.empty = 1'b0;
                e.cyc   = t + 2 + lat;
                k++;
                np++;
            end else begin
                e.data  = '0;
                e.empty = 1'b1;
                e.cyc   = t + 1;
            end
            expq.push_back(e);
            last_gfx_m[i] = g;
            if (g) ng--;
            else   nc--;
            t = e.cyc + 1;
        end
        pop_base[i] = pops[i];
        exp_pops[i] = np;
    endtask

    task automatic issue(input int i, input int nc, input int ng);
        predict(i, nc, ng, cyc);
        tgt_cpu[i] = tgt_cpu[i] + nc;
        tgt_gfx[i] = tgt_gfx[i] + ng;
    endtask

    task automatic wait_done(input int i, input bit chk_pops);
        int n;
        n = 0;
        while (n < 400 && !(seen_cpu[i] == tgt_cpu[i] && seen_gfx[i] == tgt_gfx[i]
                            && busy[i] == 1'b0 && !has_exp(i))) begin
            tick(1);
            n++;
        end
        if (n >= 400) check(1'b0, "timeout", n, 400);
        if (chk_pops) check(pops[i] - pop_base[i] == exp_pops[i], "pop_count",
                            pops[i] - pop_base[i], exp_pops[i]);
    endtask

    initial begin
        int t0;
        tick(1);

        // Reset held with both requests up and data queued; CPU must win the first tie
        push(4'b1100);
        push(4'b0011);
        tgt_cpu[0] = 1;
        tgt_gfx[0] = 1;
        tick(5);
        rst_n[0]      = 1'b1;
        last_gfx_m[0] = 1'b1;
        predict(0, 1, 1, cyc);
        wait_done(0, 1'b1);

        // Single CPU read
        push(4'b1000);
        issue(0, 1, 0);
        wait_done(0, 1'b1);

        // Empty FIFO read from graphics
        issue(0, 0, 1);
        wait_done(0, 1'b1);

        // Contention: both held for two reads each
        push(4'b1000);
        push(4'b0010);
        push(4'b0100);
        push(4'b0001);
        issue(0, 2, 2);
        wait_done(0, 1'b1);

        // Three-cycle read latency
        rst_n[1]      = 1'b1;
        last_gfx_m[1] = 1'b1;
        tick(1);
        push(4'b0110);
        issue(1, 1, 0);
        wait_done(1, 1'b1);

        // CPU drops its request during WAIT; response still arrives
        push(4'b1001);
        issue(1, 1, 0);
        t0 = cyc;
        while (cyc < t0 + 2) tick(1);
        drop_cpu[1] = 1'b1;
        wait_done(1, 1'b1);
        drop_cpu[1] = 1'b0;

        // Reset during WAIT, then a fresh transaction after release
        push(4'b0101);
        issue(1, 0, 1);
        t0 = cyc;
        while (cyc < t0 + 3) tick(1);
        check(busy[1] == 1'b1, "busy_in_wait", int'(busy[1]), 1);
        rst_n[1] = 1'b0;
        #1;
        check(fifo_rd_en[1] == 1'b0, "reset_rd_en", int'(fifo_rd_en[1]), 0);
        check(busy[1] == 1'b0, "reset_busy", int'(busy[1]), 0);
        tgt_gfx[1]    = seen_gfx[1];
        last_gfx_m[1] = 1'b1;
        tick(3);
        rst_n[1] = 1'b1;
        push(4'b1110);
        push(4'b0111);
        issue(1, 1, 1);
        wait_done(1, 1'b1);

        // Randomized scenarios
        for (int n = 0; n < 24; n++) begin
            int i, nc, ng, ni;
            i  = int'($urandom_range(0, 1));
            nc = int'($urandom_range(0, 2));
            ng = int'($urandom_range(0, 2));
            if (nc == 0 && ng == 0) nc = 1;
            ni = int'($urandom_range(0, 3));
            for (int k = 0; k < ni; k++) push(DW'($urandom));
            issue(i, nc, ng);
            wait_done(i, 1'b1);
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
